// File: rtl/elelock_pkg.sv
// Shared types and helpers for the electronic-lock passcode sequencer.
package elelock_pkg;

   localparam int NUM_KEYS = 10;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      CHECK,
      OPEN,
      LOCKOUT
   } state_t;

   // One-hot keypad vector to 4-bit digit value; callers qualify with a one-hot test.
   function automatic logic [3:0] keyenc(input logic [NUM_KEYS-1:0] key);
      logic [3:0] v;
      v = '0;
      for (int n = 0; n < NUM_KEYS; n++) begin
         if (key[n]) v = 4'(n);
      end
      return v;
   endfunction

endpackage

// File: rtl/elelock_keyscan.sv
// Keypad front end: turns a debounced one-hot tenkey bus into single-cycle
// press strobes with the encoded digit.
module elelock_keyscan
   import elelock_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] i_tenkey,
   output logic                o_press,
   output logic [3:0]          o_digit
);

   logic [NUM_KEYS-1:0] r_tenkey_q;
   logic                w_onehot;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_tenkey_q <= '0;
      else       r_tenkey_q <= i_tenkey;
   end

   // A press needs a clean all-zero cycle before it, so key rollover never registers.
   assign w_onehot = (i_tenkey != '0) && ((i_tenkey & (i_tenkey - NUM_KEYS'(1))) == '0);
   assign o_press  = w_onehot && (r_tenkey_q == '0);
   assign o_digit  = keyenc(i_tenkey);

endmodule

// File: rtl/elelock_seq.sv
// Passcode sequencer: assembles key presses into a code, opens the lock on a
// match, and enforces a timed alarm lockout after repeated wrong codes.
//
//   state   | meaning
//   IDLE    | locked, waiting for the first digit
//   ENTRY   | collecting digits, entry timer running
//   CHECK   | one-cycle compare of the full code
//   OPEN    | unlocked until close is requested
//   LOCKOUT | alarm on, all input ignored until lockout timer expires
module elelock_seq
   import elelock_pkg::*;
#(
   parameter int          DIGITS        = 4,
   parameter logic [15:0] SECRET        = 16'h1234,
   parameter int          MAX_FAIL      = 3,
   parameter int          LOCKOUT_CYC   = 1000,
   parameter int          ENTRY_TIMEOUT = 500
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] tenkey,
   input  logic                close,
   output logic                lock,
   output logic                alarm,
   output logic [1:0]          fail_cnt,
   output logic [2:0]          digit_cnt
);

   localparam int CODE_W = 4 * DIGITS;
   localparam int ET_W   = $clog2(ENTRY_TIMEOUT) + 1;
   localparam int LT_W   = $clog2(LOCKOUT_CYC) + 1;

   state_t              r_state, w_state_nxt;
   logic [CODE_W-1:0]   r_code, w_code_nxt, w_shift;
   logic [ET_W-1:0]     r_etmr, w_etmr_nxt;
   logic [LT_W-1:0]     r_ltmr, w_ltmr_nxt;
   logic [1:0]          r_fail, w_fail_nxt;
   logic [2:0]          r_dcnt, w_dcnt_nxt;
   logic                r_lock, r_alarm;
   logic                w_press;
   logic [3:0]          w_digit;

   elelock_keyscan u_keyscan (
      .clk      (clk),
      .reset    (reset),
      .i_tenkey (tenkey),
      .o_press  (w_press),
      .o_digit  (w_digit)
   );

   assign w_shift = (r_code << 4) | CODE_W'(w_digit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_code  <= '0;
         r_etmr  <= '0;
         r_ltmr  <= '0;
         r_fail  <= '0;
         r_dcnt  <= '0;
         r_lock  <= 1'b1;
         r_alarm <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_code  <= w_code_nxt;
         r_etmr  <= w_etmr_nxt;
         r_ltmr  <= w_ltmr_nxt;
         r_fail  <= w_fail_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_lock  <= (w_state_nxt != OPEN);
         r_alarm <= (w_state_nxt == LOCKOUT);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_code_nxt  = r_code;
      w_etmr_nxt  = r_etmr;
      w_ltmr_nxt  = r_ltmr;
      w_fail_nxt  = r_fail;
      w_dcnt_nxt  = r_dcnt;
      unique case (r_state)
         IDLE: begin
            if (w_press) begin
               w_code_nxt  = CODE_W'(w_digit);
               w_dcnt_nxt  = 3'd1;
               w_etmr_nxt  = '0;
               w_state_nxt = (DIGITS == 1) ? CHECK : ENTRY;
            end
         end
         ENTRY: begin
            if (close) begin
               w_code_nxt  = '0;
               w_dcnt_nxt  = '0;
               w_state_nxt = IDLE;
            end else if (w_press) begin
               w_code_nxt = w_shift;
               w_dcnt_nxt = r_dcnt + 3'd1;
               w_etmr_nxt = '0;
               if (r_dcnt + 3'd1 == 3'(DIGITS)) w_state_nxt = CHECK;
            end else if (r_etmr == ET_W'(ENTRY_TIMEOUT - 1)) begin
               w_code_nxt  = '0;
               w_dcnt_nxt  = '0;
               w_state_nxt = IDLE;
            end else begin
               w_etmr_nxt = r_etmr + ET_W'(1);
            end
         end
         CHECK: begin
            w_code_nxt = '0;
            w_dcnt_nxt = '0;
            if (r_code == SECRET[CODE_W-1:0]) begin
               w_fail_nxt  = '0;
               w_state_nxt = OPEN;
            end else if ({1'b0, r_fail} + 3'd1 < 3'(MAX_FAIL)) begin
               w_fail_nxt  = r_fail + 2'd1;
               w_state_nxt = IDLE;
            end else begin
               w_fail_nxt  = 2'(MAX_FAIL);
               w_ltmr_nxt  = '0;
               w_state_nxt = LOCKOUT;
            end
         end
         OPEN: begin
            if (close) w_state_nxt = IDLE;
         end
         LOCKOUT: begin
            if (r_ltmr == LT_W'(LOCKOUT_CYC - 1)) begin
               w_ltmr_nxt  = '0;
               w_fail_nxt  = '0;
               w_state_nxt = IDLE;
            end else begin
               w_ltmr_nxt = r_ltmr + LT_W'(1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign lock      = r_lock;
   assign alarm     = r_alarm;
   assign fail_cnt  = r_fail;
   assign digit_cnt = r_dcnt;

endmodule

// File: tb/tb_elelock_seq.sv
// Directed bench for elelock_seq: expected {lock,alarm,fail_cnt,digit_cnt}
// snapshots are queued with each stimulus step and popped when sampled.
module tb_elelock_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] tenkey;
   logic       close;
   logic       lock, alarm;
   logic [1:0] fail_cnt;
   logic [2:0] digit_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic [6:0] val;
   } exp_t;

   exp_t sb[$];

   elelock_seq #(.LOCKOUT_CYC(20), .ENTRY_TIMEOUT(10)) dut (
      .clk       (clk),
      .reset     (reset),
      .tenkey    (tenkey),
      .close     (close),
      .lock      (lock),
      .alarm     (alarm),
      .fail_cnt  (fail_cnt),
      .digit_cnt (digit_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ev(input logic l, input logic a,
                                     input logic [1:0] f, input logic [2:0] c);
      return {l, a, f, c};
   endfunction

   task automatic push(input string tag, input logic [6:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic chk();
      exp_t       e;
      logic [6:0] obs;
      obs = {lock, alarm, fail_cnt, digit_cnt};
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL sb_empty obs=%b exp=<none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b (lock,alarm,fail[2],dcnt[3])", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic expect_now(input string tag, input logic [6:0] val);
      push(tag, val);
      chk();
   endtask

   // Key held two cycles then one idle cycle; e1 is expected after the press
   // edge, e2 after the following edge.
   task automatic key(input int d, input logic [6:0] e1, input logic [6:0] e2, input string tag);
      tenkey = 10'd1 << d;
      push({tag, "_a"}, e1);
      @(negedge clk);
      chk();
      push({tag, "_b"}, e2);
      @(negedge clk);
      chk();
      tenkey = '0;
      @(negedge clk);
   endtask

   task automatic enter_code(input logic [15:0] code, input logic [1:0] f,
                             input logic [6:0] final_e, input string tag);
      logic [3:0] dg;
      for (int i = 0; i < 3; i++) begin
         dg = code[15-4*i -: 4];
         key(int'(dg), ev(1, 0, f, 3'(i + 1)), ev(1, 0, f, 3'(i + 1)),
             $sformatf("%s_d%0d", tag, i));
      end
      key(int'(code[3:0]), ev(1, 0, f, 3'd4), final_e, {tag, "_d3"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      reset  = 1'b1;
      tenkey = '0;
      close  = 1'b0;
      repeat (2) @(negedge clk);
      expect_now("reset", ev(1, 0, 0, 0));
      reset = 1'b0;
      @(negedge clk);

      // correct code opens two edges after the final press
      enter_code(16'h1234, 2'd0, ev(0, 0, 0, 0), "open");
      expect_now("open_hold", ev(0, 0, 0, 0));

      close = 1'b1;
      @(negedge clk);
      expect_now("close_relock", ev(1, 0, 0, 0));
      close = 1'b0;
      key(5, ev(1, 0, 0, 1), ev(1, 0, 0, 1), "after_close");

      // close beats a same-cycle press in ENTRY
      close  = 1'b1;
      tenkey = 10'd1 << 6;
      @(negedge clk);
      expect_now("close_prio", ev(1, 0, 0, 0));
      close  = 1'b0;
      tenkey = '0;
      @(negedge clk);

      enter_code(16'h9999, 2'd0, ev(1, 0, 1, 0), "bad1");
      enter_code(16'h9999, 2'd1, ev(1, 0, 2, 0), "bad2");
      enter_code(16'h9999, 2'd2, ev(1, 1, 3, 0), "bad3");
      key(1, ev(1, 1, 3, 0), ev(1, 1, 3, 0), "lockout_key");
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         expect_now($sformatf("lockout_c%0d", i + 6), ev(1, 1, 3, 0));
      end
      @(negedge clk);
      expect_now("lockout_exit", ev(1, 0, 0, 0));

      // entry timeout keeps fail_cnt; a later success clears it
      enter_code(16'h5678, 2'd0, ev(1, 0, 1, 0), "bad4");
      key(1, ev(1, 0, 1, 1), ev(1, 0, 1, 1), "to_d0");
      key(2, ev(1, 0, 1, 2), ev(1, 0, 1, 2), "to_d1");
      repeat (5) @(negedge clk);
      expect_now("to_wait", ev(1, 0, 1, 2));
      repeat (2) @(negedge clk);
      expect_now("to_edge_minus1", ev(1, 0, 1, 2));
      @(negedge clk);
      expect_now("to_expired", ev(1, 0, 1, 0));
      enter_code(16'h1234, 2'd1, ev(0, 0, 0, 0), "reopen");
      close = 1'b1;
      @(negedge clk);
      expect_now("reclose", ev(1, 0, 0, 0));
      close = 1'b0;
      @(negedge clk);

      // press qualification: multi-bit, held key, rollover
      tenkey = 10'b0000000110;
      @(negedge clk);
      expect_now("multibit_a", ev(1, 0, 0, 0));
      @(negedge clk);
      expect_now("multibit_b", ev(1, 0, 0, 0));
      tenkey = '0;
      @(negedge clk);
      tenkey = 10'd1 << 3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         expect_now($sformatf("held_%0d", i), ev(1, 0, 0, 1));
      end
      tenkey = 10'd1 << 4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expect_now($sformatf("rollover_%0d", i), ev(1, 0, 0, 1));
      end
      tenkey = '0;
      @(negedge clk);
      expect_now("release", ev(1, 0, 0, 1));
      close = 1'b1;
      @(negedge clk);
      expect_now("clear_entry", ev(1, 0, 0, 0));
      close = 1'b0;
      @(negedge clk);

      // async reset mid-entry
      key(1, ev(1, 0, 0, 1), ev(1, 0, 0, 1), "rs_d0");
      key(2, ev(1, 0, 0, 2), ev(1, 0, 0, 2), "rs_d1");
      key(3, ev(1, 0, 0, 3), ev(1, 0, 0, 3), "rs_d2");
      reset = 1'b1;
      #1;
      expect_now("reset_mid_entry", ev(1, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // async reset mid-lockout
      enter_code(16'h9999, 2'd0, ev(1, 0, 1, 0), "rl1");
      enter_code(16'h9999, 2'd1, ev(1, 0, 2, 0), "rl2");
      enter_code(16'h9999, 2'd2, ev(1, 1, 3, 0), "rl3");
      reset = 1'b1;
      #1;
      expect_now("reset_mid_lockout", ev(1, 0, 0, 0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      expect_now("post_reset_idle", ev(1, 0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
